// File: rtl/cdb_pkg.sv
// Shared CDB types and default sizing for the arbiter and its users.
// XLEN falls back to 32 when the build does not supply it.
`ifndef XLEN
`define XLEN 32
`endif

package cdb_pkg;

    localparam int CDB_NUM_REQ   = 4;
    localparam int CDB_TAG_WIDTH = 4;
    localparam int CDB_XLEN      = `XLEN;
    localparam int CDB_SRC_W     = $clog2(CDB_NUM_REQ);

    typedef struct packed {
        logic                     valid;
        logic [CDB_TAG_WIDTH-1:0] tag;
        logic [CDB_XLEN-1:0]      value;
        logic [CDB_SRC_W-1:0]     src;
    } cdb_struct;

    function automatic cdb_struct cdb_pack(
        input logic                     valid,
        input logic [CDB_TAG_WIDTH-1:0] tag,
        input logic [CDB_XLEN-1:0]      value,
        input logic [CDB_SRC_W-1:0]     src
    );
        cdb_struct s;
        s.valid = valid;
        s.tag   = tag;
        s.value = value;
        s.src   = src;
        return s;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational find-first-set starting at a rotating pointer, wrapping
// from NUM_REQ-1 back to 0; produces a one-hot grant and its index.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               found
);

    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        index = '0;
        found = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                index      = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: one registered broadcast per cycle.
// Optional per-unit stall counters are built when CDB_PERF_EN is defined.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ    = CDB_NUM_REQ,
    parameter int TAG_WIDTH  = CDB_TAG_WIDTH,
    parameter int DATA_WIDTH = CDB_XLEN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_value_i,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag_i,
    output logic [NUM_REQ-1:0]              busy_o,
    input  logic                            flush_i,
    output logic                            cdb_valid_o,
    output logic [DATA_WIDTH-1:0]           cdb_value_o,
    output logic [TAG_WIDTH-1:0]            cdb_tag_o,
    output logic [$clog2(NUM_REQ)-1:0]      cdb_src_o
`ifdef CDB_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]           stall_cnt_o
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]      ptr_reg;
    logic [IDX_W-1:0]      ptr_next;
    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_any;
    logic [DATA_WIDTH-1:0] value_arr [NUM_REQ];
    logic [TAG_WIDTH-1:0]  tag_arr   [NUM_REQ];

    logic                  cdb_valid_reg;
    logic [DATA_WIDTH-1:0] cdb_value_reg;
    logic [TAG_WIDTH-1:0]  cdb_tag_reg;
    logic [IDX_W-1:0]      cdb_src_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unit
            assign value_arr[gi] = req_value_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign tag_arr[gi]   = req_tag_i[gi*TAG_WIDTH +: TAG_WIDTH];
            assign busy_o[gi]    = req_valid_i[gi] & ~grant[gi];
        end
    endgenerate

    // Reset and flush both squash arbitration, so every requester sees busy.
    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (req_valid_i),
        .ptr    (ptr_reg),
        .enable (~rst & ~flush_i),
        .grant  (grant),
        .index  (grant_idx),
        .found  (grant_any)
    );

    assign ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg       <= '0;
            cdb_valid_reg <= 1'b0;
            cdb_value_reg <= '0;
            cdb_tag_reg   <= '0;
            cdb_src_reg   <= '0;
        end else begin
            cdb_valid_reg <= grant_any;
            if (grant_any) begin
                ptr_reg       <= ptr_next;
                cdb_value_reg <= value_arr[grant_idx];
                cdb_tag_reg   <= tag_arr[grant_idx];
                cdb_src_reg   <= grant_idx;
            end
        end
    end

    assign cdb_valid_o = cdb_valid_reg;
    assign cdb_value_o = cdb_value_reg;
    assign cdb_tag_o   = cdb_tag_reg;
    assign cdb_src_o   = cdb_src_reg;

`ifdef CDB_PERF_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stall
            logic [15:0] stall_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    stall_reg <= '0;
                end else if (busy_o[gi] && stall_reg != 16'hFFFF) begin
                    stall_reg <= stall_reg + 16'd1;
                end
            end
            assign stall_cnt_o[gi*16 +: 16] = stall_reg;
        end
    endgenerate
`endif

endmodule
